// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ==========================================================================
// pipe_stage_reg : valid/ready pipeline stage register with optional 2-entry
// skid buffer (PIPE_STAGE_SKID_EN), synchronous flush and bubble ctrl gating.
// Revision 1.0
// ==========================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [TAG_W-1:0]  r_m_tag;

  logic w_m_v;
  logic w_s_v;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_m_in;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [TAG_W-1:0]  r_s_tag;
  logic              r_in_ready;
  logic              w_load_m_s;
  logic              w_load_s_in;

  assign w_s_v    = (r_state == ST_FULL);
  assign in_ready = r_in_ready;
`else
  assign w_s_v    = 1'b0;
  // Without the skid slot the stage can only accept if M frees this cycle.
  assign in_ready = !w_m_v || out_ready;
`endif

  assign w_m_v      = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = w_m_v && out_ready;

  assign out_valid = w_m_v;
  assign out_data  = r_m_data;
  assign out_tag   = r_m_tag;
  assign out_ctrl  = w_m_v ? r_m_ctrl : '0;
  assign occupancy = {1'b0, w_m_v} + {1'b0, w_s_v};

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_load_m_s  = 1'b0;
    w_load_s_in = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_m_in = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_m_in = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (w_in_fire) begin
            w_load_s_in = 1'b1;
            w_state_nxt = ST_FULL;
`endif
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_out_fire) begin
            w_load_m_s  = 1'b1;
            w_state_nxt = ST_ONE;
          end
`else
          w_state_nxt = ST_EMPTY;
`endif
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers only move on a load; flush leaves data/tag untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_data <= '0;
      r_m_ctrl <= '0;
      r_m_tag  <= '0;
    end else if (w_load_m_in) begin
      r_m_data <= in_data;
      r_m_ctrl <= in_ctrl;
      r_m_tag  <= in_tag;
`ifdef PIPE_STAGE_SKID_EN
    end else if (w_load_m_s) begin
      r_m_data <= r_s_data;
      r_m_ctrl <= r_s_ctrl;
      r_m_tag  <= r_s_tag;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_data <= '0;
      r_s_ctrl <= '0;
      r_s_tag  <= '0;
    end else if (w_load_s_in) begin
      r_s_data <= in_data;
      r_s_ctrl <= in_ctrl;
      r_s_tag  <= in_tag;
    end
  end

  // Flopped copy of !s_v so in_ready has no path from out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Self-checking bench for pipe_stage_reg: queue-based reference model plus
// directed literal checks and randomized traffic.
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int TW = 5;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [TW-1:0] out_tag;
  logic [1:0]    occupancy;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [TW-1:0] t;
  } ent_t;

  ent_t q[$];
  ent_t shown = '0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // The stage is a FIFO of capacity 2 (skid) or 1; the head is what M shows,
  // and M keeps showing the last head once the FIFO drains or is flushed.
  function automatic bit model_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic model_step();
    bit ofire;
    bit ifire;
    ofire = (q.size() > 0) && out_ready;
    ifire = in_valid && model_ready();
    if (flush) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back('{d: in_data, c: in_ctrl, t: in_tag});
    end
    if (q.size() > 0) shown = q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic [TW-1:0] t);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_tag   = t;
  endtask

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("cyc_out_valid", DW'(out_valid), DW'(q.size() != 0));
      chk("cyc_out_ctrl", DW'(out_ctrl), (q.size() != 0) ? DW'(q[0].c) : '0);
      chk("cyc_out_data", out_data, shown.d);
      chk("cyc_out_tag", DW'(out_tag), DW'(shown.t));
      chk("cyc_occupancy", DW'(occupancy), DW'(q.size()));
      chk("cyc_in_ready", DW'(in_ready), DW'(model_ready()));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", DW'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_occupancy", DW'(occupancy), '0);
    chk("reset_in_ready", DW'(in_ready), DW'(1));
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Streaming 1..8 with out_ready high: 1-cycle latency, no stalls.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DW'(k), CW'(k + 16), TW'(k));
      tick();
      chk("stream_data", out_data, DW'(k));
      chk("stream_valid", DW'(out_valid), DW'(1));
      chk("stream_in_ready", DW'(in_ready), DW'(1));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stream_drained", DW'(out_valid), '0);

    // Bubble: ctrl on the input must never leak out while nothing is valid.
    drive(1'b0, DW'(77), 8'hFF, 5'd3);
    repeat (3) tick();
    chk("bubble_ctrl", DW'(out_ctrl), '0);

    // Back-pressure with A then B.
    out_ready = 1'b0;
    drive(1'b1, DW'('hA), 8'h81, 5'd10);
    tick();
    drive(1'b1, DW'('hB), 8'h82, 5'd11);
    if (SKID) begin
      tick();
      drive(1'b0, '0, '0, '0);
      chk("bp_occ", DW'(occupancy), DW'(2));
      chk("bp_in_ready", DW'(in_ready), '0);
      chk("bp_head_a", out_data, DW'('hA));
      out_ready = 1'b1;
      tick();
      chk("bp_head_b", out_data, DW'('hB));
      chk("bp_ctrl_b", DW'(out_ctrl), DW'(8'h82));
      tick();
      chk("bp_empty", DW'(out_valid), '0);
    end else begin
      chk("bp_occ", DW'(occupancy), DW'(1));
      chk("bp_in_ready_lo", DW'(in_ready), '0);
      tick();
      chk("bp_still_a", out_data, DW'('hA));
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_follow", DW'(in_ready), DW'(1));
      tick();
      chk("bp_head_b", out_data, DW'('hB));
      chk("bp_occ_max1", DW'(occupancy), DW'(1));
      drive(1'b0, '0, '0, '0);
      tick();
      chk("bp_empty", DW'(out_valid), '0);
    end

    // Flush while holding entries, with C offered in the same cycle.
    out_ready = 1'b0;
    drive(1'b1, DW'('hA1), 8'h11, 5'd1);
    tick();
    drive(1'b1, DW'('hB2), 8'h22, 5'd2);
    tick();
    drive(1'b1, DW'('hC3), 8'h33, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush_valid", DW'(out_valid), '0);
    chk("flush_ctrl", DW'(out_ctrl), '0);
    chk("flush_occ", DW'(occupancy), '0);
    chk("flush_in_ready", DW'(in_ready), DW'(1));
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_no_c", DW'(out_valid), '0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
            CW'($urandom), TW'($urandom));
      out_ready = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, DW'('hD4), 8'h44, 5'd4);
    tick();
    drive(1'b1, DW'('hE5), 8'h55, 5'd5);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("pre_reset_occ", DW'(occupancy), SKID ? DW'(2) : DW'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", DW'(out_valid), '0);
    chk("async_rst_ctrl", DW'(out_ctrl), '0);
    chk("async_rst_data", out_data, '0);
    chk("async_rst_tag", DW'(out_tag), '0);
    chk("async_rst_occ", DW'(occupancy), '0);
    chk("async_rst_in_ready", DW'(in_ready), DW'(1));
    q.delete();
    shown = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, DW'('hF6), 8'h66, 5'd6);
    tick();
    chk("post_reset_first", out_data, DW'('hF6));
    drive(1'b0, '0, '0, '0);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register. It is the successor to the fixed-width MEM/WB latch and is usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Data and control payloads carry a valid/ready handshake, with a 2-entry skid buffer for full throughput under back-pressure. It also supports synchronous flush and zeroes control bits on bubbles, so a squashed slot never writes the register file or memory.

## Interface
Parameters:
- DATA_W, 128, data payload width (e.g. ALU result + read data)
- CTRL_W, 8, control payload width (RegWrite, MemtoReg, ...); forced to 0 on bubbles
- TAG_W, 5, destination-register tag width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept; registered
- in_data  input  DATA_W  upstream data
- in_ctrl  input  CTRL_W  upstream control
- in_tag  input  TAG_W  upstream destination tag
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  held data
- out_ctrl  output  CTRL_W  held control, 0 when out_valid=0
- out_tag  output  TAG_W  held tag
- occupancy  output  2  entries held (0..2)

## Operation
- Storage:
  - Main register M {data, ctrl, tag, m_v} drives all outputs.
  - Skid register S {data, ctrl, tag, s_v}.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !s_v. out_valid = m_v. occupancy = m_v + s_v.
- States: EMPTY (m_v=0, s_v=0), ONE (1,0), FULL (1,1).
- EMPTY:
  - in_fire → M←in, ONE.
- ONE:
  - in_fire & out_fire → M←in, stay ONE.
  - in_fire & !out_fire → S←in, FULL.
  - !in_fire & out_fire → EMPTY.
  - Otherwise hold.
- FULL:
  - out_fire → M←S, s_v←0, ONE.
  - Otherwise hold. in_fire is impossible because in_ready=0.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush.
- out_ctrl = m_v ? M.ctrl : 0. out_data and out_tag show M contents regardless of m_v.
- flush has priority over everything. Next state is EMPTY, m_v=s_v=0. An in_fire in the same cycle is discarded. Data and tag registers keep their values.
- Reset: m_v=0, s_v=0, all data/ctrl/tag registers 0. Reset values are out_valid=0, out_ctrl=0, out_data=0, out_tag=0, occupancy=0, in_ready=1.

## Timing
- Latency is 1 cycle from in_fire to out_valid when the stage starts EMPTY or ONE and drains.
- Throughput is 1 entry/cycle with out_ready held high.
- in_ready is a flop output with no combinational path from out_ready.
- flush sampled at edge N gives out_valid=0 and in_ready=1 after edge N.
- reset_n falling asserts the reset values immediately, independent of clk. Mid-transfer contents are lost.
- Deassertion is synchronised externally. The first in_fire is honoured on the first rising edge with reset_n=1.
- Simultaneous flush and out_fire: the downstream entry counts as consumed. The stage is empty afterwards.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Behaviour as above, with the skid register S present.
  - in_ready is registered.
- PIPE_STAGE_SKID_EN undefined:
  - S is removed and FULL is unreachable. occupancy never exceeds 1.
  - in_ready = !m_v | out_ready (combinational).
  - in_fire & out_fire in ONE replaces M in the same cycle.
  - All other rules unchanged.

## Test plan
- Reset: assert reset_n=0 mid-stream with occupancy=2 → outputs immediately 0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, feed data 1..8 back-to-back → out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Back-pressure: out_ready=0, push A then B → occupancy=2, in_ready=0. Release out_ready → A then B delivered in order, no loss.
- Flush with occupancy=2 plus simultaneous in_fire of C → next cycle out_valid=0, out_ctrl=0x00, occupancy=0. C never appears.
- Bubble gating: in_ctrl=0xFF with in_valid=0 → out_ctrl stays 0x00.
- Macro off: repeat the back-pressure test → occupancy max 1, in_ready follows out_ready in the same cycle.
